// File: rtl/fpnew_lane_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fpnew_lane_sequencer
// Brief    : Issues one SIMD op over NumUnits lane units in beats, reassembles
//            the packed result and collapses status. Option: FPNEW_LANE_SEQ_SKIP_EN
// Revision : 1.0 - initial release
// ============================================================================
module fpnew_lane_sequencer #(
  parameter int unsigned Width       = 64,
  parameter int unsigned FpWidth     = 16,
  parameter int unsigned NumUnits    = 2,
  parameter int unsigned NumOperands = 3,
  parameter type         TagType     = logic
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    in_valid_i,
  output logic                                    in_ready_o,
  input  logic [NumOperands*Width-1:0]            operands_i,
  input  logic                                    vectorial_op_i,
  input  logic [Width/FpWidth-1:0]                simd_mask_i,
  input  TagType                                  tag_i,
  input  logic                                    flush_i,
  output logic                                    unit_valid_o,
  input  logic                                    unit_ready_i,
  output logic [NumUnits*NumOperands*FpWidth-1:0] unit_operands_o,
  output logic [NumUnits-1:0]                     unit_active_o,
  input  logic                                    unit_out_valid_i,
  output logic                                    unit_out_ready_o,
  input  logic [NumUnits*FpWidth-1:0]             unit_result_i,
  input  logic [NumUnits*5-1:0]                   unit_status_i,
  input  logic                                    unit_ext_bit_i,
  output logic [Width-1:0]                        result_o,
  output logic [4:0]                              status_o,
  output logic                                    extension_bit_o,
  output TagType                                  tag_o,
  output logic                                    out_valid_o,
  input  logic                                    out_ready_i,
  output logic                                    busy_o
);
  localparam int unsigned NUM_LANES = Width / FpWidth;
  localparam int unsigned NUM_BEATS = NUM_LANES / NumUnits;
  localparam int unsigned CNT_W     = $clog2(NUM_BEATS + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t                       r_state;
  logic [NumOperands*Width-1:0] r_operands;
  logic [NUM_LANES-1:0]         r_mask;
  logic                         r_vec;
  TagType                       r_tag;
  logic [CNT_W-1:0]             r_total;
  logic [CNT_W-1:0]             r_issue_cnt;
  logic [CNT_W-1:0]             r_collect_cnt;
  logic [Width-1:0]             r_result;
  logic [NUM_LANES-1:0]         r_filled;
  logic [4:0]                   r_status;
  logic                         r_ext;
  logic [NumUnits-1:0]          r_active;

  logic [NUM_BEATS-1:0] w_live, w_acc_live;
  logic [CNT_W-1:0]     w_acc_total, w_acc_first, w_issue_next, w_collect_next;
  logic                 w_issue, w_collect;
  logic [4:0]           w_status_acc;
  int                   w_col_base, w_iss_base;

  // A beat is live when it has to be issued and awaited.
  always_comb begin
    for (int b = 0; b < NUM_BEATS; b++) begin
`ifdef FPNEW_LANE_SEQ_SKIP_EN
      w_live[b]     = !r_vec || (|r_mask[b*NumUnits +: NumUnits]);
      w_acc_live[b] = !vectorial_op_i || (|simd_mask_i[b*NumUnits +: NumUnits]);
`else
      w_live[b]     = 1'b1;
      w_acc_live[b] = 1'b1;
`endif
    end
  end

  // First live beat at or after 'from'; 'total' when none remains.
  function automatic logic [CNT_W-1:0] next_beat(input logic [CNT_W-1:0] from,
                                                 input logic [CNT_W-1:0] total,
                                                 input logic [NUM_BEATS-1:0] live);
    logic [CNT_W-1:0] nb;
    logic             found;
    nb    = total;
    found = 1'b0;
    for (int b = 0; b < NUM_BEATS; b++) begin
      if (!found && CNT_W'(b) >= from && CNT_W'(b) < total && live[b]) begin
        nb    = CNT_W'(b);
        found = 1'b1;
      end
    end
    return nb;
  endfunction

  assign in_ready_o       = (r_state == IDLE);
  assign busy_o           = (r_state != IDLE);
  assign out_valid_o      = (r_state == DONE);
  assign unit_out_ready_o = (r_state != DONE);
  assign unit_valid_o     = (r_state == RUN) && (r_issue_cnt < r_total);
  assign unit_active_o    = r_active;
  assign status_o         = r_status;
  assign extension_bit_o  = r_ext;
  assign tag_o            = r_tag;

  assign w_issue     = unit_valid_o && unit_ready_i;
  assign w_collect   = ((r_state == RUN) || (r_state == DRAIN)) && unit_out_valid_i &&
                       (r_collect_cnt < r_total);
  assign w_acc_total = vectorial_op_i ? CNT_W'(NUM_BEATS) : CNT_W'(1);
  assign w_acc_first = next_beat('0, w_acc_total, w_acc_live);

  always_comb begin
    w_issue_next   = w_issue ? next_beat(r_issue_cnt + CNT_W'(1), r_total, w_live) : r_issue_cnt;
    w_collect_next = w_collect ? next_beat(r_collect_cnt + CNT_W'(1), r_total, w_live)
                               : r_collect_cnt;
    w_col_base = (r_collect_cnt < CNT_W'(NUM_BEATS)) ? int'(r_collect_cnt) * int'(NumUnits) : 0;
    w_iss_base = (r_issue_cnt < CNT_W'(NUM_BEATS)) ? int'(r_issue_cnt) * int'(NumUnits) : 0;
    w_status_acc = '0;
    for (int u = 0; u < NumUnits; u++) begin
      if (r_active[u] && r_mask[w_col_base + u]) w_status_acc = w_status_acc | unit_status_i[u*5 +: 5];
    end
  end

  always_comb begin
    unit_operands_o = '0;
    for (int u = 0; u < NumUnits; u++) begin
      for (int o = 0; o < NumOperands; o++) begin
        unit_operands_o[(u*NumOperands + o)*FpWidth +: FpWidth] =
          r_operands[o*Width + (w_iss_base + u)*FpWidth +: FpWidth];
      end
    end
  end

  // Lanes never written by a unit carry the replicated extension bit.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign result_o[l*FpWidth +: FpWidth] = r_filled[l] ? r_result[l*FpWidth +: FpWidth]
                                                        : {FpWidth{r_ext}};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= IDLE;
      r_operands    <= '0;
      r_mask        <= '0;
      r_vec         <= 1'b0;
      r_tag         <= '0;
      r_total       <= '0;
      r_issue_cnt   <= '0;
      r_collect_cnt <= '0;
      r_result      <= '0;
      r_filled      <= '0;
      r_status      <= '0;
      r_ext         <= 1'b0;
      r_active      <= '0;
    end else if (flush_i) begin
      r_state       <= IDLE;
      r_issue_cnt   <= '0;
      r_collect_cnt <= '0;
      r_status      <= '0;
      r_active      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid_i) begin
            r_operands    <= operands_i;
            r_mask        <= simd_mask_i;
            r_vec         <= vectorial_op_i;
            r_tag         <= tag_i;
            r_total       <= w_acc_total;
            r_issue_cnt   <= w_acc_first;
            r_collect_cnt <= w_acc_first;
            r_filled      <= '0;
            r_status      <= '0;
            r_ext         <= 1'b0;
            r_active      <= vectorial_op_i ? {NumUnits{1'b1}} : NumUnits'(1);
            r_state       <= RUN;
          end
        end
        RUN, DRAIN: begin
          r_issue_cnt <= w_issue_next;
          if (w_collect) begin
            r_collect_cnt <= w_collect_next;
            r_status      <= r_status | w_status_acc;
            if (r_filled == '0) r_ext <= unit_ext_bit_i;
            for (int u = 0; u < NumUnits; u++) begin
              if (r_active[u]) begin
                r_result[(w_col_base + u)*FpWidth +: FpWidth] <= unit_result_i[u*FpWidth +: FpWidth];
                r_filled[w_col_base + u] <= 1'b1;
              end
            end
          end
          if (w_collect_next == r_total) r_state <= DONE;
          else if (w_issue_next == r_total) r_state <= DRAIN;
        end
        DONE: begin
          if (out_ready_i) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fpnew_lane_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpnew_lane_sequencer
// Brief    : Randomized bench for fpnew_lane_sequencer with a lane-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpnew_lane_sequencer;
  localparam int W = 64, FW = 16, NU = 2, NO = 3, NL = W / FW, NB = NL / NU;

  logic                clk = 1'b0;
  logic                rst_i = 1'b1;
  logic                in_valid_i = 1'b0, in_ready_o;
  logic [NO*W-1:0]     operands_i = '0;
  logic                vectorial_op_i = 1'b0;
  logic [NL-1:0]       simd_mask_i = '0;
  logic [7:0]          tag_i = '0, tag_o;
  logic                flush_i = 1'b0;
  logic                unit_valid_o, unit_ready_i = 1'b0;
  logic [NU*NO*FW-1:0] unit_operands_o;
  logic [NU-1:0]       unit_active_o;
  logic                unit_out_valid_i = 1'b0, unit_out_ready_o;
  logic [NU*FW-1:0]    unit_result_i = '0;
  logic [NU*5-1:0]     unit_status_i = '0;
  logic                unit_ext_bit_i = 1'b0;
  logic [W-1:0]        result_o;
  logic [4:0]          status_o;
  logic                extension_bit_o, out_valid_o, out_ready_i = 1'b0, busy_o;

  fpnew_lane_sequencer #(.Width(W), .FpWidth(FW), .NumUnits(NU), .NumOperands(NO),
                         .TagType(logic [7:0])) dut (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .operands_i(operands_i), .vectorial_op_i(vectorial_op_i), .simd_mask_i(simd_mask_i),
    .tag_i(tag_i), .flush_i(flush_i), .unit_valid_o(unit_valid_o), .unit_ready_i(unit_ready_i),
    .unit_operands_o(unit_operands_o), .unit_active_o(unit_active_o),
    .unit_out_valid_i(unit_out_valid_i), .unit_out_ready_o(unit_out_ready_o),
    .unit_result_i(unit_result_i), .unit_status_i(unit_status_i), .unit_ext_bit_i(unit_ext_bit_i),
    .result_o(result_o), .status_o(status_o), .extension_bit_o(extension_bit_o), .tag_o(tag_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .busy_o(busy_o));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Stand-in arithmetic of a lane unit; the model applies it per lane of the op.
  function automatic logic [15:0] lane_fn(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    return (a ^ {b[7:0], b[15:8]}) + c;
  endfunction
  function automatic logic [4:0] st_fn(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    return a[4:0] ^ c[4:0] ^ {4'b0, b[0]};
  endfunction

  typedef struct {
    int               due;
    logic [NU*FW-1:0] res;
    logic [NU*5-1:0]  st;
    logic             ext;
  } ret_t;
  ret_t q[$];

  task automatic check_reset_state(input string pfx);
    check_val({pfx, "_in_ready"}, in_ready_o, 1);
    check_val({pfx, "_unit_valid"}, unit_valid_o, 0);
    check_val({pfx, "_out_valid"}, out_valid_o, 0);
    check_val({pfx, "_busy"}, busy_o, 0);
    check_val({pfx, "_unit_active"}, unit_active_o, 0);
    check_val({pfx, "_result"}, result_o, 0);
    check_val({pfx, "_status"}, status_o, 0);
    check_val({pfx, "_ext"}, extension_bit_o, 0);
    check_val({pfx, "_tag"}, tag_o, 0);
    check_val({pfx, "_unit_out_ready"}, unit_out_ready_o, 1);
  endtask

  // mode: 0 random waits, 1 zero-wait units, 2 scripted backpressure
  task automatic run_op(input logic vec, input logic [NL-1:0] mask, input logic ext,
                        input int mode, input int flush_after);
    logic [NO*W-1:0] ops;
    logic [7:0]      tg;
    int              beats[$];
    bit              live[NB];
    logic [W-1:0]    exp_res;
    logic [4:0]      exp_st;
    logic            exp_ext;
    logic [15:0]     a, b, c;
    int              issued, stall_i, stall_o, t, flush_t, lane, bt;
    bit              flushed, seen_out, done, rdy, used;
    ret_t            r;

    for (int i = 0; i < NO*W/32; i++) ops[i*32 +: 32] = $urandom;
    tg = 8'($urandom);
    for (int i = 0; i < NB; i++) begin
      if (!vec) live[i] = (i == 0);
      else begin
`ifdef FPNEW_LANE_SEQ_SKIP_EN
        live[i] = (mask[i*NU +: NU] != 0);
`else
        live[i] = 1'b1;
`endif
      end
      if (live[i]) beats.push_back(i);
    end
    exp_ext = (beats.size() > 0) ? ext : 1'b0;
    exp_st  = '0;
    for (int l = 0; l < NL; l++) begin
      used = live[l / NU] && (vec || (l % NU) == 0);
      a = ops[0*W + l*FW +: FW];
      b = ops[1*W + l*FW +: FW];
      c = ops[2*W + l*FW +: FW];
      exp_res[l*FW +: FW] = used ? lane_fn(a, b, c) : {FW{exp_ext}};
      if (used && mask[l]) exp_st = exp_st | st_fn(a, b, c);
    end

    t = 0;
    @(negedge clk);
    while (!in_ready_o && t < 50) begin @(negedge clk); t++; end
    check_val("idle_before_op", in_ready_o, 1);
    in_valid_i = 1'b1; operands_i = ops; vectorial_op_i = vec; simd_mask_i = mask; tag_i = tg;
    issued = 0; stall_i = 0; stall_o = 0; flush_t = 0;
    flushed = 0; seen_out = 0; done = 0;

    for (t = 1; t <= 400 && !done; t++) begin
      @(negedge clk);
      in_valid_i = 1'b0; unit_ready_i = 1'b0; unit_out_valid_i = 1'b0;
      out_ready_i = 1'b0; flush_i = 1'b0;
      if (flushed) begin
        if (t == flush_t + 1) begin
          check_val("flush_busy", busy_o, 0);
          check_val("flush_unit_valid", unit_valid_o, 0);
          check_val("flush_in_ready", in_ready_o, 1);
        end
        if (q.size() == 0) begin done = 1; continue; end
      end else begin
        check_val("in_ready_busy", in_ready_o, 0);
      end
      if (q.size() > 0 && q[0].due <= t) begin
        unit_out_valid_i = 1'b1; unit_result_i = q[0].res;
        unit_status_i = q[0].st; unit_ext_bit_i = q[0].ext;
        if (flushed) check_val("sink_ready", unit_out_ready_o, 1);
        if (unit_out_ready_o) q.delete(0);
      end
      if (!flushed && flush_after > 0 && issued >= flush_after) begin
        flush_i = 1'b1; flushed = 1; flush_t = t;
      end else if (!flushed) begin
        if (unit_valid_o) begin
          check_val("issue_in_range", issued < beats.size(), 1);
          if (issued < beats.size()) begin
            bt = beats[issued];
            for (int u = 0; u < NU; u++)
              for (int o = 0; o < NO; o++) begin
                lane = bt*NU + u;
                check_val("unit_operand", unit_operands_o[(u*NO + o)*FW +: FW], ops[o*W + lane*FW +: FW]);
              end
            check_val("unit_active", unit_active_o, vec ? 2'b11 : 2'b01);
          end
          if (mode == 1) rdy = 1;
          else if (mode == 2) begin rdy = (stall_i >= 3); stall_i++; end
          else rdy = ($urandom_range(0, 3) != 0);
          if (rdy) begin
            unit_ready_i = 1'b1;
            r.due = t + 1 + ((mode == 0) ? int'($urandom_range(0, 2)) : 0);
            for (int u = 0; u < NU; u++) begin
              a = unit_operands_o[(u*NO + 0)*FW +: FW];
              b = unit_operands_o[(u*NO + 1)*FW +: FW];
              c = unit_operands_o[(u*NO + 2)*FW +: FW];
              r.res[u*FW +: FW] = lane_fn(a, b, c);
              r.st[u*5 +: 5]    = st_fn(a, b, c);
            end
            r.ext = (issued == 0) ? ext : ~ext;
            q.push_back(r);
            issued++;
          end
        end
        if (out_valid_o) begin
          if (!seen_out) begin
            seen_out = 1;
            check_val("issue_count", issued, beats.size());
            if (mode == 1) check_val("out_latency", t, beats.size() + 2);
          end
          check_val("result", result_o, exp_res);
          check_val("status", status_o, exp_st);
          check_val("ext_bit", extension_bit_o, exp_ext);
          check_val("tag", tag_o, tg);
          check_val("busy_done", busy_o, 1);
          if (mode == 2) begin rdy = (stall_o >= 4); stall_o++; end
          else if (mode == 1) rdy = 1;
          else rdy = ($urandom_range(0, 2) != 0);
          if (rdy) begin out_ready_i = 1'b1; done = 1; end
        end
      end
    end

    check_val("op_completed", done, 1);
    @(negedge clk);
    out_ready_i = 1'b0; unit_out_valid_i = 1'b0; flush_i = 1'b0; unit_ready_i = 1'b0;
    if (!done) begin
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      q.delete();
    end else if (!flushed) begin
      check_val("idle_after_out", in_ready_o, 1);
    end
  endtask

  task automatic reset_mid_run();
    @(negedge clk);
    in_valid_i = 1'b1; vectorial_op_i = 1'b1; simd_mask_i = '1;
    tag_i = 8'hA5; operands_i = {6{32'h1234_5678}};
    @(negedge clk);
    in_valid_i = 1'b0; unit_ready_i = 1'b0;
    check_val("pre_rst_busy", busy_o, 1);
    check_val("pre_rst_unit_valid", unit_valid_o, 1);
    #2 rst_i = 1'b1;
    #1 check_reset_state("async_rst");
    @(negedge clk);
    rst_i = 1'b0;
    q.delete();
  endtask

  initial begin
    logic [NL-1:0] m;
    int            fa;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_i = 1'b0;

    run_op(1'b0, 4'b0001, 1'b1, 1, -1);
    run_op(1'b1, 4'b1111, 1'b0, 1, -1);
    run_op(1'b1, 4'b0100, 1'b1, 1, -1);
    run_op(1'b1, 4'b1111, 1'b1, 2, -1);
    run_op(1'b1, 4'b1111, 1'b0, 0, 1);
    run_op(1'b1, 4'b1011, 1'b1, 1, -1);
    run_op(1'b1, 4'b0011, 1'b1, 1, -1);
    run_op(1'b1, 4'b1100, 1'b0, 1, -1);
    run_op(1'b1, 4'b0000, 1'b1, 1, -1);
    run_op(1'b0, 4'b1110, 1'b0, 2, -1);
    reset_mid_run();
    for (int i = 0; i < 80; i++) begin
      m  = NL'($urandom);
      fa = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : -1;
      run_op(1'($urandom), m, 1'($urandom), int'($urandom_range(0, 2)), fa);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
